hazard_sequencer: RTL and testbench

//  Pipeline controller for the 5-stage core. It drives the enable/flush pairs of the IF/ID,
//  ID/EX, EX/MEM and MEM/WB latches, plus the PC enable. It sequences load-use stalls,

---
 rtl/hazard_sequencer.sv | 179 +++++++++++++++++
 tb/tb_hazard_sequencer.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_sequencer.sv
// hazard_sequencer
//   Pipeline controller for the 5-stage core. Drives the enable/flush pairs of the
//   IF/ID, ID/EX, EX/MEM and MEM/WB latches and the PC enable. It sequences load-use
//   stalls, taken-branch flushes, imem/dmem wait states and the halt drain. It also
//   keeps a saturating count of stalled fetch cycles.
//
// Ports
//   CLK, nRST             clock (rising edge), async active-low reset
//   ihit, dhit            imem / dmem access completes this cycle
//   ifid_rs, ifid_rt,
//   ifid_uses_rt          source operands of the instruction in IF/ID
//   idex_dREN, idex_wsel  load flag and destination register of the ID/EX instruction
//   ex_br_taken           branch/jump resolved taken in EX
//   exmem_dREN/dWEN/halt  load / store / halt sitting in EX/MEM
//   pc_en, *_en, *_flush  latch controls (combinational, forced to 0 while nRST=0)
//   halt                  sticky processor-halted flag
//   stall_count           saturating count of pc_en=0 cycles outside DRAIN/HALTED
//
// state      | meaning
// -----------+-------------------------------------------------------------
// ST_RUN     | normal issue, all hazards checked
// ST_LDSTALL | single cycle after a load-use bubble, load-use check masked
// ST_BRWAIT  | taken branch waiting for the target fetch, pipe frozen
// ST_DRAIN   | halt reached EX/MEM, only MEM/WB advances for HALT_DRAIN cycles
// ST_HALTED  | everything frozen until reset

module hazard_sequencer #(
   parameter int STALL_W    = 16,
   parameter int HALT_DRAIN = 2
) (
   input  logic               CLK,
   input  logic               nRST,
   input  logic               ihit,
   input  logic               dhit,
   input  logic [4:0]         ifid_rs,
   input  logic [4:0]         ifid_rt,
   input  logic               ifid_uses_rt,
   input  logic               idex_dREN,
   input  logic [4:0]         idex_wsel,
   input  logic               ex_br_taken,
   input  logic               exmem_dREN,
   input  logic               exmem_dWEN,
   input  logic               exmem_halt,
   output logic               pc_en,
   output logic               ifid_en,
   output logic               ifid_flush,
   output logic               idex_en,
   output logic               idex_flush,
   output logic               exmem_en,
   output logic               exmem_flush,
   output logic               memwb_en,
   output logic               memwb_flush,
   output logic               halt,
   output logic [STALL_W-1:0] stall_count
);

   localparam int DW = (HALT_DRAIN > 1) ? $clog2(HALT_DRAIN) : 1;
   localparam logic [DW-1:0] DRAIN_LAST = (HALT_DRAIN > 1) ? DW'(HALT_DRAIN - 1) : '0;
   localparam logic [DW-1:0] DRAIN_ONE  = DW'(1);
   localparam logic [STALL_W-1:0] STALL_ONE = STALL_W'(1);

   // Control word bit order: {pc, ifid_en, ifid_flush, idex_en, idex_flush,
   //                          exmem_en, exmem_flush, memwb_en, memwb_flush}.
   // Where a flush is raised the matching enable may also be 1; the latch gives
   // flush priority, so it still loads a bubble.
   localparam logic [8:0] CTL_OFF    = 9'b0_0_0_0_0_0_0_0_0;
   localparam logic [8:0] CTL_NORMAL = 9'b1_1_0_1_0_1_0_1_0;
   localparam logic [8:0] CTL_HALT   = 9'b0_0_1_0_1_0_1_1_0;
   localparam logic [8:0] CTL_FROZEN = 9'b0_0_0_0_0_0_0_1_1;
   localparam logic [8:0] CTL_BRANCH = 9'b1_1_1_1_1_1_0_1_0;
   localparam logic [8:0] CTL_BUBBLE = 9'b0_0_0_1_1_1_0_1_0;
   localparam logic [8:0] CTL_DRAIN  = 9'b0_0_0_0_0_0_0_1_0;

   typedef enum logic [2:0] {
      ST_RUN     = 3'd0,
      ST_LDSTALL = 3'd1,
      ST_BRWAIT  = 3'd2,
      ST_DRAIN   = 3'd3,
      ST_HALTED  = 3'd4
   } state_t;

   state_t               state_q, state_d;
   logic [DW-1:0]        drain_cnt_q, drain_cnt_d;
   logic [STALL_W-1:0]   stall_count_q, stall_count_d;
   logic [8:0]           ctl;
   logic                 mem_busy;
   logic                 load_use;
   logic                 stall_state;

   assign mem_busy = (exmem_dREN | exmem_dWEN) & ~dhit;
   assign load_use = idex_dREN & (idex_wsel != 5'd0) &
                     ((idex_wsel == ifid_rs) | (ifid_uses_rt & (idex_wsel == ifid_rt)));

   always_comb begin
      state_d     = state_q;
      drain_cnt_d = drain_cnt_q;
      ctl         = CTL_OFF;
      case (state_q)
         ST_RUN, ST_LDSTALL: begin
            if (exmem_halt) begin
               ctl         = CTL_HALT;
               state_d     = ST_DRAIN;
               drain_cnt_d = '0;
            end else if (mem_busy) begin
               // Hold the current state so a pending LDSTALL survives the wait.
               ctl = CTL_FROZEN;
            end else if (ex_br_taken) begin
               if (ihit) begin
                  ctl     = CTL_BRANCH;
                  state_d = ST_RUN;
               end else begin
                  ctl     = CTL_FROZEN;
                  state_d = ST_BRWAIT;
               end
            end else if (load_use && (state_q == ST_RUN)) begin
               ctl     = CTL_BUBBLE;
               state_d = ST_LDSTALL;
            end else if (!ihit) begin
               ctl     = CTL_BUBBLE;
               state_d = ST_RUN;
            end else begin
               ctl     = CTL_NORMAL;
               state_d = ST_RUN;
            end
         end
         ST_BRWAIT: begin
            if (ihit) begin
               ctl     = CTL_BRANCH;
               state_d = ST_RUN;
            end else begin
               ctl = CTL_FROZEN;
            end
         end
         ST_DRAIN: begin
            ctl = CTL_DRAIN;
            if (drain_cnt_q == DRAIN_LAST) begin
               state_d     = ST_HALTED;
               drain_cnt_d = '0;
            end else begin
               drain_cnt_d = drain_cnt_q + DRAIN_ONE;
            end
         end
         ST_HALTED: begin
            ctl = CTL_OFF;
         end
         default: begin
            state_d     = ST_RUN;
            drain_cnt_d = '0;
         end
      endcase
   end

   assign stall_state = (state_q == ST_RUN) | (state_q == ST_LDSTALL) | (state_q == ST_BRWAIT);

   always_comb begin
      stall_count_d = stall_count_q;
      if (stall_state && !ctl[8] && (stall_count_q != '1)) begin
         stall_count_d = stall_count_q + STALL_ONE;
      end
   end

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         state_q       <= ST_RUN;
         drain_cnt_q   <= '0;
         stall_count_q <= '0;
      end else begin
         state_q       <= state_d;
         drain_cnt_q   <= drain_cnt_d;
         stall_count_q <= stall_count_d;
      end
   end

   assign {pc_en, ifid_en, ifid_flush, idex_en, idex_flush,
           exmem_en, exmem_flush, memwb_en, memwb_flush} = nRST ? ctl : CTL_OFF;
   assign halt        = (state_q == ST_HALTED);
   assign stall_count = stall_count_q;

endmodule

// File: tb/tb_hazard_sequencer.sv
// tb_hazard_sequencer
//   Self-checking bench for hazard_sequencer: a table of single-cycle vectors
//   from the reset state, hand-written multi-cycle sequences, and a randomized
//   run compared against a behavioural model of the hazard rules.

module tb_hazard_sequencer;

   localparam int HD       = 2;
   localparam int STALL_MX = 65535;

   localparam logic [8:0] P_OFF    = 9'b0_0_0_0_0_0_0_0_0;
   localparam logic [8:0] P_NORMAL = 9'b1_1_0_1_0_1_0_1_0;
   localparam logic [8:0] P_HALT   = 9'b0_0_1_0_1_0_1_1_0;
   localparam logic [8:0] P_FROZEN = 9'b0_0_0_0_0_0_0_1_1;
   localparam logic [8:0] P_BRANCH = 9'b1_1_1_1_1_1_0_1_0;
   localparam logic [8:0] P_BUBBLE = 9'b0_0_0_1_1_1_0_1_0;
   localparam logic [8:0] P_DRAIN  = 9'b0_0_0_0_0_0_0_1_0;

   logic        CLK = 1'b0;
   logic        nRST = 1'b0;
   logic        ihit, dhit, ifid_uses_rt, idex_dREN, ex_br_taken;
   logic        exmem_dREN, exmem_dWEN, exmem_halt;
   logic [4:0]  ifid_rs, ifid_rt, idex_wsel;
   logic        pc_en, ifid_en, ifid_flush, idex_en, idex_flush;
   logic        exmem_en, exmem_flush, memwb_en, memwb_flush, halt;
   logic [15:0] stall_count;

   always #5 CLK = ~CLK;

   hazard_sequencer #(.STALL_W(16), .HALT_DRAIN(HD)) dut (
      .CLK(CLK), .nRST(nRST), .ihit(ihit), .dhit(dhit),
      .ifid_rs(ifid_rs), .ifid_rt(ifid_rt), .ifid_uses_rt(ifid_uses_rt),
      .idex_dREN(idex_dREN), .idex_wsel(idex_wsel), .ex_br_taken(ex_br_taken),
      .exmem_dREN(exmem_dREN), .exmem_dWEN(exmem_dWEN), .exmem_halt(exmem_halt),
      .pc_en(pc_en), .ifid_en(ifid_en), .ifid_flush(ifid_flush),
      .idex_en(idex_en), .idex_flush(idex_flush), .exmem_en(exmem_en),
      .exmem_flush(exmem_flush), .memwb_en(memwb_en), .memwb_flush(memwb_flush),
      .halt(halt), .stall_count(stall_count)
   );

   int checks = 0;
   int errors = 0;

   // Reference model: plain flags and counters describing where the pipe is.
   bit m_halted, m_brwait, m_ldmask;
   int m_drain_left, m_stalls;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   function automatic logic [8:0] ctl_now();
      return {pc_en, ifid_en, ifid_flush, idex_en, idex_flush,
              exmem_en, exmem_flush, memwb_en, memwb_flush};
   endfunction

   function automatic bit m_lu();
      return idex_dREN && (idex_wsel != 0) &&
             ((idex_wsel == ifid_rs) || (ifid_uses_rt && (idex_wsel == ifid_rt)));
   endfunction

   function automatic bit m_busy();
      return (exmem_dREN || exmem_dWEN) && !dhit;
   endfunction

   function automatic logic [8:0] m_expect();
      if (!nRST || m_halted) return P_OFF;
      if (m_drain_left > 0)  return P_DRAIN;
      if (m_brwait)          return ihit ? P_BRANCH : P_FROZEN;
      if (exmem_halt)        return P_HALT;
      if (m_busy())          return P_FROZEN;
      if (ex_br_taken)       return ihit ? P_BRANCH : P_FROZEN;
      if (m_lu() && !m_ldmask) return P_BUBBLE;
      if (!ihit)             return P_BUBBLE;
      return P_NORMAL;
   endfunction

   task automatic m_reset();
      m_halted = 0; m_brwait = 0; m_ldmask = 0; m_drain_left = 0; m_stalls = 0;
   endtask

   task automatic m_clock();
      logic [8:0] e;
      e = m_expect();
      if (!nRST) return;
      if (!e[8] && !m_halted && (m_drain_left == 0) && (m_stalls < STALL_MX)) m_stalls++;
      if (m_halted) begin
      end else if (m_drain_left > 0) begin
         m_drain_left--;
         if (m_drain_left == 0) m_halted = 1;
      end else if (m_brwait) begin
         if (ihit) m_brwait = 0;
      end else if (exmem_halt) begin
         m_drain_left = HD;
         m_ldmask     = 0;
      end else if (m_busy()) begin
      end else if (ex_br_taken) begin
         m_brwait = !ihit;
         m_ldmask = 0;
      end else if (m_lu() && !m_ldmask) begin
         m_ldmask = 1;
      end else begin
         m_ldmask = 0;
      end
   endtask

   task automatic idle_inputs();
      ihit = 1; dhit = 1; ifid_rs = 0; ifid_rt = 0; ifid_uses_rt = 0;
      idex_dREN = 0; idex_wsel = 0; ex_br_taken = 0;
      exmem_dREN = 0; exmem_dWEN = 0; exmem_halt = 0;
   endtask

   // Called at posedge+1; compares mid-cycle, clocks, returns at posedge+1.
   task automatic step(input string nm);
      #1;
      chk({nm, "_ctl"},   32'(ctl_now()),   32'(m_expect()));
      chk({nm, "_halt"},  32'(halt),        32'(m_halted));
      chk({nm, "_stall"}, 32'(stall_count), 32'(m_stalls));
      @(posedge CLK);
      m_clock();
      #1;
   endtask

   task automatic do_reset();
      #2;
      nRST = 0;
      m_reset();
      #1;
      chk("reset_ctl",   32'(ctl_now()),   32'(P_OFF));
      chk("reset_halt",  32'(halt),        32'(0));
      chk("reset_stall", 32'(stall_count), 32'(0));
      @(posedge CLK);
      #1;
      nRST = 1;
   endtask

   typedef struct {
      string      nm;
      logic       ih, dh, urt, ldr, br, dr, dw, hl;
      logic [4:0] rs, rt, ws;
      logic [8:0] exp_ctl;
      logic [15:0] exp_stall;
   } vec_t;

   function automatic vec_t mk(input string nm, input logic ih, input logic dh,
                               input logic [4:0] rs, input logic [4:0] rt, input logic urt,
                               input logic ldr, input logic [4:0] ws, input logic br,
                               input logic dr, input logic dw, input logic hl,
                               input logic [8:0] ec, input logic [15:0] es);
      vec_t v;
      v.nm = nm; v.ih = ih; v.dh = dh; v.rs = rs; v.rt = rt; v.urt = urt; v.ldr = ldr;
      v.ws = ws; v.br = br; v.dr = dr; v.dw = dw; v.hl = hl; v.exp_ctl = ec; v.exp_stall = es;
      return v;
   endfunction

   vec_t vecs[$];

   initial begin
      idle_inputs();
      //              name            ih dh rs rt urt ldr ws br dr dw hl  ctl       stall
      vecs.push_back(mk("normal",      1, 1, 0, 0, 0,  0, 0, 0, 0, 0, 0, P_NORMAL, 16'd0));
      vecs.push_back(mk("lu_rs",       1, 1, 5, 0, 0,  1, 5, 0, 0, 0, 0, P_BUBBLE, 16'd1));
      vecs.push_back(mk("lu_r0",       1, 1, 0, 0, 0,  1, 0, 0, 0, 0, 0, P_NORMAL, 16'd0));
      vecs.push_back(mk("lu_rt",       1, 1, 3, 7, 1,  1, 7, 0, 0, 0, 0, P_BUBBLE, 16'd1));
      vecs.push_back(mk("rt_unused",   1, 1, 3, 7, 0,  1, 7, 0, 0, 0, 0, P_NORMAL, 16'd0));
      vecs.push_back(mk("no_ihit",     0, 1, 0, 0, 0,  0, 0, 0, 0, 0, 0, P_BUBBLE, 16'd1));
      vecs.push_back(mk("br_ihit",     1, 1, 0, 0, 0,  0, 0, 1, 0, 0, 0, P_BRANCH, 16'd0));
      vecs.push_back(mk("br_noihit",   0, 1, 0, 0, 0,  0, 0, 1, 0, 0, 0, P_FROZEN, 16'd1));
      vecs.push_back(mk("ld_busy",     1, 0, 0, 0, 0,  0, 0, 0, 1, 0, 0, P_FROZEN, 16'd1));
      vecs.push_back(mk("ld_hit",      1, 1, 0, 0, 0,  0, 0, 0, 1, 0, 0, P_NORMAL, 16'd0));
      vecs.push_back(mk("halt_busy",   1, 0, 0, 0, 0,  0, 0, 0, 0, 1, 1, P_HALT,   16'd1));
      vecs.push_back(mk("busy_br_lu",  1, 0, 4, 0, 0,  1, 4, 1, 0, 1, 0, P_FROZEN, 16'd1));
      vecs.push_back(mk("br_over_lu",  1, 1, 4, 0, 0,  1, 4, 1, 0, 0, 0, P_BRANCH, 16'd0));

      do_reset();

      foreach (vecs[k]) begin
         do_reset();
         ihit = vecs[k].ih; dhit = vecs[k].dh; ifid_rs = vecs[k].rs; ifid_rt = vecs[k].rt;
         ifid_uses_rt = vecs[k].urt; idex_dREN = vecs[k].ldr; idex_wsel = vecs[k].ws;
         ex_br_taken = vecs[k].br; exmem_dREN = vecs[k].dr; exmem_dWEN = vecs[k].dw;
         exmem_halt = vecs[k].hl;
         #1;
         chk({"vec_", vecs[k].nm, "_ctl"}, 32'(ctl_now()), 32'(vecs[k].exp_ctl));
         @(posedge CLK);
         #1;
         chk({"vec_", vecs[k].nm, "_stall"}, 32'(stall_count), 32'(vecs[k].exp_stall));
         idle_inputs();
      end

      // Reset in the middle of the halt drain.
      do_reset();
      idle_inputs();
      exmem_halt = 1;
      step("t1_halt");
      exmem_halt = 0;
      step("t1_drain");
      do_reset();
      #1;
      chk("t1_run_ctl", 32'(ctl_now()), 32'(P_NORMAL));
      step("t1_after");

      // Load-use: one bubble, then the masked cycle issues normally.
      do_reset();
      idle_inputs();
      idex_dREN = 1; idex_wsel = 5; ifid_rs = 5;
      #1;
      chk("t2_pc_en", 32'(pc_en), 32'(0));
      chk("t2_idex_flush", 32'(idex_flush), 32'(1));
      step("t2_bubble");
      chk("t2_next_ctl", 32'(ctl_now()), 32'(P_NORMAL));
      step("t2_masked");
      idle_inputs();
      step("t2_after");

      // Zero destination never stalls.
      do_reset();
      idle_inputs();
      idex_dREN = 1; idex_wsel = 0; ifid_rs = 0;
      step("t3_a");
      step("t3_b");
      chk("t3_stall", 32'(stall_count), 32'(0));

      // Taken branch while the target fetch is missing.
      do_reset();
      idle_inputs();
      ex_br_taken = 1; ihit = 0;
      step("t4_res");
      ex_br_taken = 0;
      for (int c = 0; c < 3; c++) step("t4_wait");
      chk("t4_stall", 32'(stall_count), 32'(4));
      ihit = 1;
      #1;
      chk("t4_release_ctl", 32'(ctl_now()), 32'(P_BRANCH));
      step("t4_release");
      step("t4_after");

      // Store waiting on dmem with a taken branch behind it.
      do_reset();
      idle_inputs();
      exmem_dWEN = 1; dhit = 0; ex_br_taken = 1;
      for (int c = 0; c < 4; c++) step("t5_frozen");
      chk("t5_stall", 32'(stall_count), 32'(4));
      dhit = 1;
      #1;
      chk("t5_dhit_ctl", 32'(ctl_now()), 32'(P_BRANCH));
      step("t5_dhit");

      // Halt drain then sticky halt.
      do_reset();
      idle_inputs();
      exmem_halt = 1;
      step("t6_halt");
      exmem_halt = 0;
      for (int c = 0; c < HD; c++) begin
         ex_br_taken = 1'($urandom_range(0, 1));
         ihit = 1'($urandom_range(0, 1));
         #1;
         chk("t6_drain_ctl", 32'(ctl_now()), 32'(P_DRAIN));
         chk("t6_drain_halt", 32'(halt), 32'(0));
         step("t6_drain");
      end
      for (int c = 0; c < 5; c++) begin
         ihit = 1'($urandom_range(0, 1));
         exmem_halt = 1'($urandom_range(0, 1));
         #1;
         chk("t6_halted_ctl", 32'(ctl_now()), 32'(P_OFF));
         chk("t6_halted", 32'(halt), 32'(1));
         step("t6_hold");
      end

      // Stall counter saturation.
      do_reset();
      idle_inputs();
      ihit = 0;
      repeat (65534) @(posedge CLK);
      #1;
      chk("t7_below_sat", 32'(stall_count), 32'(65534));
      repeat (7) @(posedge CLK);
      #1;
      chk("t7_sat", 32'(stall_count), 32'(16'hFFFF));
      m_stalls = STALL_MX;
      step("t7_hold");

      // Randomized run against the model.
      do_reset();
      idle_inputs();
      for (int i = 0; i < 3000; i++) begin
         ihit         = ($urandom_range(0, 3) != 0);
         dhit         = ($urandom_range(0, 4) < 3);
         ifid_rs      = 5'($urandom_range(0, 3));
         ifid_rt      = 5'($urandom_range(0, 3));
         ifid_uses_rt = 1'($urandom_range(0, 1));
         idex_dREN    = ($urandom_range(0, 4) < 2);
         idex_wsel    = 5'($urandom_range(0, 3));
         ex_br_taken  = ($urandom_range(0, 6) == 0);
         exmem_dREN   = ($urandom_range(0, 3) == 0);
         exmem_dWEN   = ($urandom_range(0, 3) == 0);
         exmem_halt   = ($urandom_range(0, 59) == 0);
         if (m_brwait) begin
            exmem_dREN = 0; exmem_dWEN = 0; exmem_halt = 0;
         end
         if (($urandom_range(0, 199) == 0) || (m_halted && ($urandom_range(0, 5) == 0)))
            do_reset();
         else
            step("rnd");
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
